// File: rtl/pipe_stage_regs.sv
// Y86-64 F/D/E/M/W pipeline register bank with stall/bubble handling,
// debug event counters and a sticky stall+bubble conflict flag.
module pipe_stage_regs #(
  parameter int WORD  = 64,
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             F_stall,
  input  logic             D_stall,
  input  logic             D_bubble,
  input  logic             E_bubble,
  input  logic             M_bubble,
  input  logic             W_stall,
  input  logic [WORD-1:0]  f_predPC,
  input  logic [3:0]       f_stat,
  input  logic [3:0]       f_icode,
  input  logic [3:0]       f_ifun,
  input  logic [3:0]       f_rA,
  input  logic [3:0]       f_rB,
  input  logic [WORD-1:0]  f_valC,
  input  logic [WORD-1:0]  f_valP,
  input  logic [3:0]       d_stat,
  input  logic [3:0]       d_icode,
  input  logic [3:0]       d_ifun,
  input  logic [3:0]       d_srcA,
  input  logic [3:0]       d_srcB,
  input  logic [3:0]       d_dstE,
  input  logic [3:0]       d_dstM,
  input  logic [WORD-1:0]  d_valC,
  input  logic [WORD-1:0]  d_valA,
  input  logic [WORD-1:0]  d_valB,
  input  logic [3:0]       e_stat,
  input  logic [3:0]       e_icode,
  input  logic [3:0]       e_dstE,
  input  logic [3:0]       e_dstM,
  input  logic             e_Cnd,
  input  logic [WORD-1:0]  e_valE,
  input  logic [WORD-1:0]  e_valA,
  input  logic [3:0]       m_stat,
  input  logic [3:0]       m_icode,
  input  logic [3:0]       m_dstE,
  input  logic [3:0]       m_dstM,
  input  logic [WORD-1:0]  m_valE,
  input  logic [WORD-1:0]  m_valM,
  output logic [WORD-1:0]  F_predPC,
  output logic [3:0]       D_stat,
  output logic [3:0]       D_icode,
  output logic [3:0]       D_ifun,
  output logic [3:0]       D_rA,
  output logic [3:0]       D_rB,
  output logic [WORD-1:0]  D_valC,
  output logic [WORD-1:0]  D_valP,
  output logic [3:0]       E_stat,
  output logic [3:0]       E_icode,
  output logic [3:0]       E_ifun,
  output logic [3:0]       E_srcA,
  output logic [3:0]       E_srcB,
  output logic [3:0]       E_dstE,
  output logic [3:0]       E_dstM,
  output logic [WORD-1:0]  E_valC,
  output logic [WORD-1:0]  E_valA,
  output logic [WORD-1:0]  E_valB,
  output logic [3:0]       M_stat,
  output logic [3:0]       M_icode,
  output logic [3:0]       M_dstE,
  output logic [3:0]       M_dstM,
  output logic             M_Cnd,
  output logic [WORD-1:0]  M_valE,
  output logic [WORD-1:0]  M_valA,
  output logic [3:0]       W_stat,
  output logic [3:0]       W_icode,
  output logic [3:0]       W_dstE,
  output logic [3:0]       W_dstM,
  output logic [WORD-1:0]  W_valE,
  output logic [WORD-1:0]  W_valM,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] bubble_cnt,
  output logic             ctl_err
);

  localparam logic [3:0] STAT_AOK = 4'h1;
  localparam logic [3:0] INOP     = 4'h1;
  localparam logic [3:0] RNONE    = 4'hF;

  // F stage
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)        F_predPC <= '0;
    else if (!F_stall) F_predPC <= f_predPC;
  end

  // D stage: stall has priority over bubble
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n || (!D_stall && D_bubble)) begin
      {D_stat, D_icode, D_ifun} <= {STAT_AOK, INOP, 4'h0};
      {D_rA, D_rB}              <= {RNONE, RNONE};
      {D_valC, D_valP}          <= '0;
    end else if (!D_stall) begin
      {D_stat, D_icode, D_ifun} <= {f_stat, f_icode, f_ifun};
      {D_rA, D_rB}              <= {f_rA, f_rB};
      {D_valC, D_valP}          <= {f_valC, f_valP};
    end
  end

  // E stage
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n || E_bubble) begin
      {E_stat, E_icode, E_ifun}         <= {STAT_AOK, INOP, 4'h0};
      {E_srcA, E_srcB, E_dstE, E_dstM}  <= {RNONE, RNONE, RNONE, RNONE};
      {E_valC, E_valA, E_valB}          <= '0;
    end else begin
      {E_stat, E_icode, E_ifun}         <= {d_stat, d_icode, d_ifun};
      {E_srcA, E_srcB, E_dstE, E_dstM}  <= {d_srcA, d_srcB, d_dstE, d_dstM};
      {E_valC, E_valA, E_valB}          <= {d_valC, d_valA, d_valB};
    end
  end

  // M stage
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n || M_bubble) begin
      {M_stat, M_icode, M_dstE, M_dstM} <= {STAT_AOK, INOP, RNONE, RNONE};
      M_Cnd                             <= 1'b0;
      {M_valE, M_valA}                  <= '0;
    end else begin
      {M_stat, M_icode, M_dstE, M_dstM} <= {e_stat, e_icode, e_dstE, e_dstM};
      M_Cnd                             <= e_Cnd;
      {M_valE, M_valA}                  <= {e_valE, e_valA};
    end
  end

  // W stage
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      {W_stat, W_icode, W_dstE, W_dstM} <= {STAT_AOK, INOP, RNONE, RNONE};
      {W_valE, W_valM}                  <= '0;
    end else if (!W_stall) begin
      {W_stat, W_icode, W_dstE, W_dstM} <= {m_stat, m_icode, m_dstE, m_dstM};
      {W_valE, W_valM}                  <= {m_valE, m_valM};
    end
  end

  // Debug counters: at most one increment per cycle each, wrapping naturally
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt  <= '0;
      bubble_cnt <= '0;
      ctl_err    <= 1'b0;
    end else begin
      if (F_stall || D_stall || W_stall)    stall_cnt  <= stall_cnt + 1'b1;
      if (D_bubble || E_bubble || M_bubble) bubble_cnt <= bubble_cnt + 1'b1;
      if (D_stall && D_bubble)              ctl_err    <= 1'b1;
    end
  end

endmodule

// File: tb/tb_pipe_stage_regs.sv
// Randomized scoreboard bench for pipe_stage_regs: a stage-level model predicts
// the register bank after each edge; a monitor compares on the falling edge.
module tb_pipe_stage_regs;
  localparam int W  = 64;
  localparam int CW = 4;

  typedef struct packed {
    logic [3:0] stat, icode, ifun, ra, rb;
    logic [W-1:0] valc, valp;
  } d_t;
  typedef struct packed {
    logic [3:0] stat, icode, ifun, srca, srcb, dste, dstm;
    logic [W-1:0] valc, vala, valb;
  } e_t;
  typedef struct packed {
    logic [3:0] stat, icode, dste, dstm;
    logic cnd;
    logic [W-1:0] vale, vala;
  } m_t;
  typedef struct packed {
    logic [3:0] stat, icode, dste, dstm;
    logic [W-1:0] vale, valm;
  } w_t;
  typedef struct packed {
    logic [W-1:0] pc;
    d_t d; e_t e; m_t m; w_t w;
    logic [CW-1:0] sc, bc;
    logic err;
  } s_t;

  localparam d_t D_NOP = '{stat:4'h1, icode:4'h1, ifun:4'h0, ra:4'hF, rb:4'hF, valc:'0, valp:'0};
  localparam e_t E_NOP = '{stat:4'h1, icode:4'h1, ifun:4'h0, srca:4'hF, srcb:4'hF,
                           dste:4'hF, dstm:4'hF, valc:'0, vala:'0, valb:'0};
  localparam m_t M_NOP = '{stat:4'h1, icode:4'h1, dste:4'hF, dstm:4'hF, cnd:1'b0, vale:'0, vala:'0};
  localparam w_t W_NOP = '{stat:4'h1, icode:4'h1, dste:4'hF, dstm:4'hF, vale:'0, valm:'0};

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic fs = 0, ds = 0, db = 0, eb = 0, mb = 0, ws = 0;
  logic [W-1:0] f_pc = '0;
  d_t fin = '0;
  e_t din = '0;
  m_t ein = '0;
  w_t min = '0;
  s_t act, mdl, rst_img;
  s_t q[$];
  int checks = 0;
  int failures = 0;

  logic [W-1:0] F_predPC;
  logic [3:0] D_stat, D_icode, D_ifun, D_rA, D_rB;
  logic [W-1:0] D_valC, D_valP;
  logic [3:0] E_stat, E_icode, E_ifun, E_srcA, E_srcB, E_dstE, E_dstM;
  logic [W-1:0] E_valC, E_valA, E_valB;
  logic [3:0] M_stat, M_icode, M_dstE, M_dstM;
  logic M_Cnd;
  logic [W-1:0] M_valE, M_valA;
  logic [3:0] W_stat, W_icode, W_dstE, W_dstM;
  logic [W-1:0] W_valE, W_valM;
  logic [CW-1:0] stall_cnt, bubble_cnt;
  logic ctl_err;

  always #5 clk = ~clk;

  pipe_stage_regs #(.WORD(W), .CNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n),
    .F_stall(fs), .D_stall(ds), .D_bubble(db), .E_bubble(eb), .M_bubble(mb), .W_stall(ws),
    .f_predPC(f_pc),
    .f_stat(fin.stat), .f_icode(fin.icode), .f_ifun(fin.ifun), .f_rA(fin.ra), .f_rB(fin.rb),
    .f_valC(fin.valc), .f_valP(fin.valp),
    .d_stat(din.stat), .d_icode(din.icode), .d_ifun(din.ifun), .d_srcA(din.srca),
    .d_srcB(din.srcb), .d_dstE(din.dste), .d_dstM(din.dstm),
    .d_valC(din.valc), .d_valA(din.vala), .d_valB(din.valb),
    .e_stat(ein.stat), .e_icode(ein.icode), .e_dstE(ein.dste), .e_dstM(ein.dstm),
    .e_Cnd(ein.cnd), .e_valE(ein.vale), .e_valA(ein.vala),
    .m_stat(min.stat), .m_icode(min.icode), .m_dstE(min.dste), .m_dstM(min.dstm),
    .m_valE(min.vale), .m_valM(min.valm),
    .F_predPC(F_predPC),
    .D_stat(D_stat), .D_icode(D_icode), .D_ifun(D_ifun), .D_rA(D_rA), .D_rB(D_rB),
    .D_valC(D_valC), .D_valP(D_valP),
    .E_stat(E_stat), .E_icode(E_icode), .E_ifun(E_ifun), .E_srcA(E_srcA), .E_srcB(E_srcB),
    .E_dstE(E_dstE), .E_dstM(E_dstM), .E_valC(E_valC), .E_valA(E_valA), .E_valB(E_valB),
    .M_stat(M_stat), .M_icode(M_icode), .M_dstE(M_dstE), .M_dstM(M_dstM), .M_Cnd(M_Cnd),
    .M_valE(M_valE), .M_valA(M_valA),
    .W_stat(W_stat), .W_icode(W_icode), .W_dstE(W_dstE), .W_dstM(W_dstM),
    .W_valE(W_valE), .W_valM(W_valM),
    .stall_cnt(stall_cnt), .bubble_cnt(bubble_cnt), .ctl_err(ctl_err)
  );

  assign act.pc  = F_predPC;
  assign act.d   = {D_stat, D_icode, D_ifun, D_rA, D_rB, D_valC, D_valP};
  assign act.e   = {E_stat, E_icode, E_ifun, E_srcA, E_srcB, E_dstE, E_dstM, E_valC, E_valA, E_valB};
  assign act.m   = {M_stat, M_icode, M_dstE, M_dstM, M_Cnd, M_valE, M_valA};
  assign act.w   = {W_stat, W_icode, W_dstE, W_dstM, W_valE, W_valM};
  assign act.sc  = stall_cnt;
  assign act.bc  = bubble_cnt;
  assign act.err = ctl_err;

  task automatic chk(input string name, input logic [255:0] a, input logic [255:0] e);
    checks++;
    if (a !== e) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, a, e);
    end
  endtask

  task automatic cmp_snap(input string tag, input s_t a, input s_t e);
    chk({tag, ".F_predPC"}, 256'(a.pc), 256'(e.pc));
    chk({tag, ".D"}, 256'(a.d), 256'(e.d));
    chk({tag, ".E"}, 256'(a.e), 256'(e.e));
    chk({tag, ".M"}, 256'(a.m), 256'(e.m));
    chk({tag, ".W"}, 256'(a.w), 256'(e.w));
    chk({tag, ".stall_cnt"}, 256'(a.sc), 256'(e.sc));
    chk({tag, ".bubble_cnt"}, 256'(a.bc), 256'(e.bc));
    chk({tag, ".ctl_err"}, 256'(a.err), 256'(e.err));
  endtask

  // Monitor: one expected image per clock edge, compared on the falling edge
  initial begin
    s_t e;
    forever begin
      @(negedge clk);
      if (rst_n && q.size() > 0) begin
        e = q.pop_front();
        cmp_snap("edge", act, e);
      end
    end
  end

  task automatic rand_inputs();
    f_pc = {$urandom, $urandom};
    fin  = {$urandom, $urandom, $urandom, $urandom, $urandom};
    din  = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
    ein  = {$urandom, $urandom, $urandom, $urandom, $urandom};
    min  = {$urandom, $urandom, $urandom, $urandom, $urandom};
  endtask

  // Reference: each stage loads, holds or takes a nop image on every edge
  task automatic step(input logic [5:0] ctl);
    {fs, ds, db, eb, mb, ws} = ctl;
    rand_inputs();
    if (!fs) mdl.pc = f_pc;
    if (!ds) mdl.d = db ? D_NOP : fin;
    mdl.e = eb ? E_NOP : din;
    mdl.m = mb ? M_NOP : ein;
    if (!ws) mdl.w = min;
    if (fs || ds || ws) mdl.sc = mdl.sc + 1'b1;
    if (db || eb || mb) mdl.bc = mdl.bc + 1'b1;
    if (ds && db) mdl.err = 1'b1;
    q.push_back(mdl);
    @(posedge clk);
    #1;
  endtask

  // Assert reset between edges, check the nop image immediately and after an edge
  task automatic do_reset(input string tag);
    @(negedge clk);
    #1;
    rand_inputs();
    {fs, ds, db, eb, mb, ws} = 6'b111111;
    rst_n = 1'b0;
    #1;
    cmp_snap({tag, ".async"}, act, rst_img);
    @(posedge clk);
    #1;
    cmp_snap({tag, ".held"}, act, rst_img);
    mdl = rst_img;
    @(negedge clk);
    rst_n = 1'b1;
    #1;
  endtask

  initial begin
    int waits;
    rst_img = '{pc:'0, d:D_NOP, e:E_NOP, m:M_NOP, w:W_NOP, sc:'0, bc:'0, err:1'b0};
    mdl = rst_img;
    do_reset("reset0");
    // free flow, load/use, mispredict, W stall, conflict, bubble wrap
    repeat (5) step(6'b000000);
    step(6'b110100);
    step(6'b000000);
    step(6'b001100);
    repeat (2) step(6'b000000);
    repeat (3) step(6'b000001);
    step(6'b011000);
    repeat (3) step(6'b000000);
    repeat (16) step(6'b000100);
    repeat (3) step(6'b000010);
    do_reset("reset_mid");
    repeat (600) begin
      logic [5:0] c;
      for (int i = 0; i < 6; i++) c[i] = ($urandom_range(0, 3) == 0);
      step(c);
    end
    do_reset("reset_end");
    repeat (20) step(6'($urandom));
    waits = 0;
    while (q.size() > 0 && waits < 10) begin
      @(posedge clk);
      waits++;
    end
    checks++;
    if (q.size() != 0) begin
      failures++;
      $display("FAIL drain pending=%0d required=0", q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/pipe_stage_regs.md
Name: pipe_stage_regs

Overview:
- Y86-64 pipeline register bank for the F, D, E, M and W stages.
- Consumes the stall/bubble controls produced by pipeline control logic: F_stall, D_stall, D_bubble, E_bubble, M_bubble, W_stall.
- Each rising clock edge, every stage register does exactly one of three things: loads its upstream values, holds its contents (stall), or injects a nop (bubble).
- Also keeps stall/bubble event counters and a sticky protocol-error flag for debug.

Parameters:
- WORD, 64, data/address width of PC, valC, valP, valA, valB, valE and valM.
- CNT_W, 32, width of each performance counter.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- F_stall, D_stall, D_bubble, E_bubble, M_bubble, W_stall  in  1 each  pipeline controls
- f_predPC  in  WORD  next predicted PC
- f_stat, f_icode, f_ifun, f_rA, f_rB  in  4 each  fetch outputs
- f_valC, f_valP  in  WORD each  fetch outputs
- d_stat, d_icode, d_ifun, d_srcA, d_srcB, d_dstE, d_dstM  in  4 each  decode outputs
- d_valC, d_valA, d_valB  in  WORD each  decode outputs
- e_stat, e_icode, e_dstE, e_dstM  in  4 each  execute outputs
- e_Cnd  in  1  execute condition
- e_valE, e_valA  in  WORD each  execute outputs
- m_stat, m_icode, m_dstE, m_dstM  in  4 each  memory outputs
- m_valE, m_valM  in  WORD each  memory outputs
- F_predPC  out  WORD
- D_stat, D_icode, D_ifun, D_rA, D_rB  out  4 each
- D_valC, D_valP  out  WORD each
- E_stat, E_icode, E_ifun, E_srcA, E_srcB, E_dstE, E_dstM  out  4 each
- E_valC, E_valA, E_valB  out  WORD each
- M_stat, M_icode, M_dstE, M_dstM  out  4 each
- M_Cnd  out  1
- M_valE, M_valA  out  WORD each
- W_stat, W_icode, W_dstE, W_dstM  out  4 each
- W_valE, W_valM  out  WORD each
- stall_cnt, bubble_cnt  out  CNT_W each  event counters
- ctl_err  out  1  sticky: stall and bubble seen on the same stage in one cycle

Behaviour:
- Nop image, used for both reset and bubble injection:
  - icode = 4'h1, stat = 4'h1 (AOK).
  - rA, rB, srcA, srcB, dstE, dstM = 4'hF (RNONE).
  - ifun, Cnd and all WORD fields = 0.
- Reset: rst_n low asynchronously forces every stage register to the nop image, F_predPC to 0, both counters to 0 and ctl_err to 0. Outputs hold these values until the first rising clk edge after rst_n rises.
- F stage: F_stall=1 holds F_predPC; otherwise F_predPC <= f_predPC. F has no bubble.
- D stage:
  - D_stall=1: hold.
  - else D_bubble=1: load nop image.
  - else: load f_* fields.
- D with D_stall and D_bubble both high: stall wins (hold), and ctl_err sets on that edge and stays set until reset.
- E stage: E_bubble=1 loads the nop image; else loads d_* fields. E has no stall.
- M stage: M_bubble=1 loads the nop image; else loads e_* fields (M_valA <= e_valA, M_Cnd <= e_Cnd).
- W stage: W_stall=1 holds; else loads m_* fields.
- Latency: exactly one cycle per stage; outputs are registered only, with no combinational path from inputs to outputs.
- Counters, updated each edge while rst_n is high:
  - stall_cnt += 1 if any of F_stall, D_stall, W_stall is high.
  - bubble_cnt += 1 if any of D_bubble, E_bubble, M_bubble is high.
  - One increment per cycle at most, no matter how many controls are high.
  - Counters wrap modulo 2^CNT_W.
- Reset mid-operation: asynchronous reset overrides any pending stall or bubble; no partial updates.
- All fields of one stage update together; no field-level enables.

Test Plan:
- Reset: drive rst_n=0 mid-cycle with non-nop values loaded -> immediately D_icode=1, D_rA=F, E_dstM=F, W_stat=1, F_predPC=0, both counters 0, ctl_err=0.
- Free flow: no controls, f_icode=6, f_valC=0x10 at edge 1 -> D_icode=6 after edge 1, E_icode=6 after edge 2, M_icode=6 after edge 3, W_icode=6 after edge 4.
- Load/use: F_stall=D_stall=E_bubble=1 for one cycle:
  - F_predPC and D_* hold.
  - E_icode=1, E_dstM=F.
  - stall_cnt=1, bubble_cnt=1.
- Mispredict: D_bubble=E_bubble=1 with E_icode=7 loaded -> D_icode=1, E_icode=1, M_icode=7, M_Cnd=e_Cnd; bubble_cnt increments by 1 only.
- Ret/W_stall: hold W_stall=1 for 3 cycles with m_icode changing -> W_* frozen; stall_cnt=3.
- Error and wrap:
  - D_stall=D_bubble=1 -> D holds, ctl_err=1, and ctl_err stays 1 after the controls drop.
  - With CNT_W=4, 16 bubble cycles -> bubble_cnt wraps to 0.
